preview_block_sequencer: RTL

Controls the next-piece preview window on the VGA screen. Accepts "show piece N" requests from game logic and defers the swap to vertical blank so the image never tears. Drives the address of a single shared block-image ROM, which holds all seven piece images back to back, using window-relative counters and piece base offsets. Converts the 2-bit ROM codes to 8-bit pixels for the top-level pixel mux.

---
 rtl/preview_pkg.sv | 49 ++++
 rtl/block_window_addr_gen.sv | 57 +++++
 rtl/preview_block_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/preview_pkg.sv
// Shared types and constants for the next-piece preview window.
package preview_pkg;

    typedef logic [2:0] piece_id_t;

    localparam piece_id_t PIECE_BLANK = 3'd7;

    localparam int WIN_X0      = 286;
    localparam int WIN_X1      = 364;
    localparam int WIN_Y0      = 407;
    localparam int WIN_Y1      = 460;
    localparam int IMG_WORDS   = (WIN_X1 - WIN_X0) * (WIN_Y1 - WIN_Y0);
    localparam int NUM_PIECES  = 7;
    localparam int VBLANK_LINE = 480;
    localparam int ADDR_W      = 15;

    localparam logic [7:0] COL_BLACK = 8'h00;
    localparam logic [7:0] COL_WHITE = 8'hFF;
    localparam logic [7:0] COL_PIECE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    // Start of a piece image inside the shared ROM; the blank piece has no image.
    function automatic logic [ADDR_W-1:0] piece_base(input piece_id_t piece);
        logic [ADDR_W-1:0] base;
        if (piece == PIECE_BLANK) begin
            base = '0;
        end else begin
            base = ADDR_W'(piece) * ADDR_W'(IMG_WORDS);
        end
        return base;
    endfunction

    // Two-bit ROM code to display colour; both middle codes share the piece colour.
    function automatic logic [7:0] colour_of(input logic [1:0] code);
        logic [7:0] colour;
        case (code)
            2'b00:   colour = COL_BLACK;
            2'b11:   colour = COL_WHITE;
            default: colour = COL_PIECE;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/block_window_addr_gen.sv
// Fixed-window address generator: window compare, saturating image offset and
// registered ROM address (base + offset). Shared by the fixed-window draw blocks.
module block_window_addr_gen
    import preview_pkg::*;
#(
    parameter int X0    = WIN_X0,
    parameter int X1    = WIN_X1,
    parameter int Y0    = WIN_Y0,
    parameter int Y1    = WIN_Y1,
    parameter int WORDS = IMG_WORDS,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   hcount,
    input  logic [9:0]    vcount,
    input  logic [AW-1:0] base,
    output logic          in_win,
    output logic [AW-1:0] addr
);

    localparam logic [AW-1:0] OFF_MAX = AW'(WORDS - 1);

    logic          in_rows;
    logic          in_cols;
    logic [AW-1:0] offset_q, offset_d;
    logic [AW-1:0] addr_q, addr_d;

    // Window compare and next offset: cleared outside the window rows, held in the
    // row margins, advanced per in-window pixel and pinned at the last image word.
    always_comb begin
        in_rows  = (vcount >= 10'(Y0)) && (vcount < 10'(Y1));
        in_cols  = (hcount >= 11'(X0)) && (hcount < 11'(X1));
        in_win   = in_rows && in_cols;
        offset_d = offset_q;
        if (!in_rows) begin
            offset_d = '0;
        end else if (in_cols && (offset_q != OFF_MAX)) begin
            offset_d = offset_q + AW'(1);
        end
        addr_d = base + offset_q;
    end

    // Offset and ROM address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
            addr_q   <= '0;
        end else begin
            offset_q <= offset_d;
            addr_q   <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/preview_block_sequencer.sv
// Next-piece preview: defers piece swaps to vertical blank, drives the shared
// block-image ROM address and turns ROM codes into preview pixels.
module preview_block_sequencer
    import preview_pkg::*;
(
    input  logic              vclk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              req_valid,
    input  logic [2:0]        req_piece,
    output logic              req_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [1:0]        rom_data,
    output logic [7:0]        pixel_out,
    output logic              pixel_valid
);

    state_t            state_q, state_d;
    piece_id_t         pending_q, pending_d;
    piece_id_t         active_q, active_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;

    logic              in_win;
    logic              win_d1_q, win_d2_q;
    logic              blank_d1_q, blank_d2_q;
    logic [7:0]        pixel_q, pixel_d;
    logic              pixel_valid_q, pixel_valid_d;

    logic              in_vblank;

    assign in_vblank = (vcount >= 10'(VBLANK_LINE));

    block_window_addr_gen u_addr_gen (
        .clk    (vclk),
        .rst    (rst),
        .hcount (hcount),
        .vcount (vcount),
        .base   (base_q),
        .in_win (in_win),
        .addr   (rom_addr)
    );

    // Request handshake: latch one request, wait for a vblank clock, then swap
    // the active piece and its ROM base in a single commit cycle.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        active_d  = active_q;
        base_d    = base_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    pending_d = (req_piece >= PIECE_BLANK) ? PIECE_BLANK : req_piece;
                    state_d   = PENDING;
                end
            end
            PENDING: begin
                if (in_vblank) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                active_d = pending_q;
                base_d   = piece_base(pending_q);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // Sequencer state and its registered handshake outputs.
    always_ff @(posedge vclk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= PIECE_BLANK;
            active_q    <= PIECE_BLANK;
            base_q      <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            base_q      <= base_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Colour stage: the two-deep flags line up with the ROM word fetched for the same pixel.
    always_comb begin
        pixel_d       = COL_BLACK;
        pixel_valid_d = 1'b0;
        if (win_d2_q && !blank_d2_q) begin
            pixel_d       = colour_of(rom_data);
            pixel_valid_d = 1'b1;
        end
    end

    // Window/blank delay line and registered pixel output.
    always_ff @(posedge vclk) begin
        if (rst) begin
            win_d1_q      <= 1'b0;
            win_d2_q      <= 1'b0;
            blank_d1_q    <= 1'b1;
            blank_d2_q    <= 1'b1;
            pixel_q       <= COL_BLACK;
            pixel_valid_q <= 1'b0;
        end else begin
            win_d1_q      <= in_win;
            win_d2_q      <= win_d1_q;
            blank_d1_q    <= (active_q == PIECE_BLANK);
            blank_d2_q    <= blank_d1_q;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign pixel_out   = pixel_q;
    assign pixel_valid = pixel_valid_q;

endmodule
